// File: rtl/mips_pc_pkg.sv
// Shared constants for the PC stage: default vectors and the sequential increment.
package mips_pc_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Redirect source chosen by the target calculator.
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2
    } redir_src_e;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Control/data bundle between the decode/exception logic and the PC stage.
interface pc_redirect_unit_if;
    import mips_pc_pkg::*;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset_sl2;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] redirect_base;
    logic        exception;
    logic [31:0] exc_pc;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        redirect_pending;
    logic        addr_err;

    // The PC stage itself.
    modport slave (
        input  stall, branch_taken, branch_offset_sl2, jump, jump_index,
               redirect_base, exception, exc_pc,
        output pc, pc_plus4, epc, redirect_pending, addr_err
    );

    // Whoever drives redirects and consumes the fetch address.
    modport master (
        output stall, branch_taken, branch_offset_sl2, jump, jump_index,
               redirect_base, exception, exc_pc,
        input  pc, pc_plus4, epc, redirect_pending, addr_err
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch/jump target generation and redirect select.
// A jump wins over a simultaneous taken branch.
module pc_target_calc
    import mips_pc_pkg::*;
(
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset_sl2,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_redirect_base,
    output logic        o_redir_valid,
    output redir_src_e  o_redir_src,
    output logic [31:0] o_redir_target
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    // Branch adds modulo 2^32; jump splices the index into the current 256 MB region.
    always_comb begin
        w_branch_target = i_redirect_base + i_branch_offset_sl2;
        w_jump_target   = {i_redirect_base[31:28], i_jump_index, 2'b00};
    end

    // Select the redirect source and its target.
    always_comb begin
        o_redir_src    = REDIR_NONE;
        o_redir_target = w_branch_target;
        if (i_jump) begin
            o_redir_src    = REDIR_JUMP;
            o_redir_target = w_jump_target;
        end else if (i_branch_taken) begin
            o_redir_src    = REDIR_BRANCH;
            o_redir_target = w_branch_target;
        end
        o_redir_valid = (o_redir_src != REDIR_NONE);
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register with stall handling, a one-deep redirect buffer for redirects
// arriving under stall, and exception vectoring with EPC capture.
module pc_redirect_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    pc_redirect_unit_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic        w_redir_valid;
    redir_src_e  w_redir_src;
    logic [31:0] w_redir_target;
    logic [31:0] w_pc_plus4;

    pc_target_calc u_target_calc (
        .i_branch_taken      (bus.branch_taken),
        .i_branch_offset_sl2 (bus.branch_offset_sl2),
        .i_jump              (bus.jump),
        .i_jump_index        (bus.jump_index),
        .i_redirect_base     (bus.redirect_base),
        .o_redir_valid       (w_redir_valid),
        .o_redir_src         (w_redir_src),
        .o_redir_target      (w_redir_target)
    );

    // Sequential next address; wraps naturally at the top of the address space.
    always_comb begin
        w_pc_plus4 = r_pc + PC_INC;
    end

    // Priority: reset, exception, stall (buffer redirect), live redirect, buffered redirect, sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_VECTOR;
            r_epc         <= 32'd0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (bus.exception) begin
            r_pc         <= EXC_VECTOR;
            r_epc        <= bus.exc_pc;
            r_pend_valid <= 1'b0;
        end else if (bus.stall) begin
            // Only the newest redirect seen under stall is kept.
            if (w_redir_valid) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_redir_target;
            end
        end else if (w_redir_valid) begin
            r_pc         <= w_redir_target;
            r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    // Drive the outputs; addr_err is a flag only and never steers sequencing.
    always_comb begin
        bus.pc               = r_pc;
        bus.pc_plus4         = w_pc_plus4;
        bus.epc              = r_epc;
        bus.redirect_pending = r_pend_valid;
        bus.addr_err         = (r_pc[1:0] != 2'b00);
    end

    // The source tag is only used for the valid decode inside the calculator.
    logic w_unused;
    always_comb begin
        w_unused = ^w_redir_src;
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the PC stage.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;

    logic clk;
    logic reset;

    pc_redirect_unit_if u_if ();

    pc_redirect_unit #(
        .RESET_VECTOR (RST_VEC),
        .EXC_VECTOR   (EXC_VEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_pend;
    logic [31:0] m_pend_tgt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, using the inputs presented during the cycle.
    task automatic model_edge();
        bit          redir;
        logic [31:0] tgt;
        redir = u_if.jump || u_if.branch_taken;
        if (u_if.jump)
            tgt = (u_if.redirect_base & 32'hF000_0000) | ({6'd0, u_if.jump_index} * 32'd4);
        else
            tgt = u_if.redirect_base + u_if.branch_offset_sl2;
        if (reset) begin
            m_pc = RST_VEC; m_epc = 32'd0; m_pend = 0;
        end else if (u_if.exception) begin
            m_pc = EXC_VEC; m_epc = u_if.exc_pc; m_pend = 0;
        end else if (u_if.stall) begin
            if (redir) begin m_pend = 1; m_pend_tgt = tgt; end
        end else if (redir) begin
            m_pc = tgt; m_pend = 0;
        end else if (m_pend) begin
            m_pc = m_pend_tgt; m_pend = 0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_model();
        check_val("pc",       u_if.pc,       m_pc);
        check_val("pc_plus4", u_if.pc_plus4, m_pc + 32'd4);
        check_val("epc",      u_if.epc,      m_epc);
        check_val("pending",  {31'd0, u_if.redirect_pending}, {31'd0, m_pend});
        check_val("addr_err", {31'd0, u_if.addr_err}, {31'd0, (m_pc % 4) != 0});
    endtask

    task automatic idle_inputs();
        u_if.stall = 0; u_if.branch_taken = 0; u_if.jump = 0; u_if.exception = 0;
        u_if.branch_offset_sl2 = 0; u_if.jump_index = 0; u_if.redirect_base = 0;
        u_if.exc_pc = 0; reset = 0;
    endtask

    // Advance one edge, update the model and compare; inputs return to idle afterwards.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        idle_inputs();
    endtask

    task automatic do_branch(input logic [31:0] base, input logic [31:0] off);
        u_if.branch_taken = 1; u_if.redirect_base = base; u_if.branch_offset_sl2 = off;
    endtask

    initial begin
        m_pc = 32'd0; m_epc = 32'd0; m_pend = 0; m_pend_tgt = 32'd0;
        idle_inputs();
        #1;

        // Reset and free-run.
        reset = 1;
        cyc();
        check_val("rst_pc", u_if.pc, 32'hBFC0_0000);
        check_val("rst_epc", u_if.epc, 32'd0);
        check_val("rst_pend", {31'd0, u_if.redirect_pending}, 32'd0);
        cyc(); check_val("run1", u_if.pc, 32'hBFC0_0004);
        cyc(); check_val("run2", u_if.pc, 32'hBFC0_0008);
        cyc(); check_val("run3", u_if.pc, 32'hBFC0_000C);

        // Jump to the top word, then wrap.
        u_if.jump = 1; u_if.redirect_base = 32'hF000_0000; u_if.jump_index = 26'h3FF_FFFF;
        cyc(); check_val("jmp_top", u_if.pc, 32'hFFFF_FFFC);
        check_val("p4_wrap", u_if.pc_plus4, 32'h0000_0000);
        cyc(); check_val("wrap", u_if.pc, 32'h0000_0000);

        // Backward branch and jump.
        do_branch(32'h0040_0010, 32'hFFFF_FFF0);
        cyc(); check_val("branch", u_if.pc, 32'h0040_0000);
        u_if.jump = 1; u_if.redirect_base = 32'h0040_0008; u_if.jump_index = 26'h010_0004;
        cyc(); check_val("jump", u_if.pc, 32'h0040_0010);

        // Jump beats a simultaneous branch.
        u_if.jump = 1; u_if.jump_index = 26'h000_0100;
        u_if.branch_taken = 1; u_if.redirect_base = 32'h1000_0000; u_if.branch_offset_sl2 = 32'h40;
        cyc(); check_val("jmp_over_br", u_if.pc, 32'h1000_0400);

        // Redirect during a 3-cycle stall.
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0020);
        cyc(); check_val("stall_hold1", u_if.pc, 32'h1000_0400);
        check_val("stall_pend", {31'd0, u_if.redirect_pending}, 32'd1);
        u_if.stall = 1; cyc();
        u_if.stall = 1; cyc(); check_val("stall_hold3", u_if.pc, 32'h1000_0400);
        cyc(); check_val("pend_apply", u_if.pc, 32'h0040_0120);
        check_val("pend_clr", {31'd0, u_if.redirect_pending}, 32'd0);

        // Newer buffered redirect overwrites the older one.
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0020); cyc();
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0100); cyc();
        u_if.stall = 1; cyc();
        cyc(); check_val("pend_newest", u_if.pc, 32'h0040_0200);

        // Live redirect beats a buffered one when stall drops.
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0020); cyc();
        do_branch(32'h0050_0000, 32'h0000_0008);
        cyc(); check_val("live_wins", u_if.pc, 32'h0050_0008);
        cyc(); check_val("live_then_seq", u_if.pc, 32'h0050_000C);

        // Exception under stall with a pending redirect.
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0020); cyc();
        u_if.stall = 1; u_if.exception = 1; u_if.exc_pc = 32'h0040_0044;
        cyc(); check_val("exc_pc", u_if.pc, 32'h8000_0180);
        check_val("exc_epc", u_if.epc, 32'h0040_0044);
        check_val("exc_pend", {31'd0, u_if.redirect_pending}, 32'd0);

        // Reset during stall with a pending redirect.
        u_if.stall = 1; do_branch(32'h0040_0100, 32'h0000_0020); cyc();
        u_if.stall = 1; reset = 1;
        cyc(); check_val("rst2_pc", u_if.pc, 32'hBFC0_0000);
        check_val("rst2_epc", u_if.epc, 32'd0);
        check_val("rst2_pend", {31'd0, u_if.redirect_pending}, 32'd0);

        // Misaligned branch target raises addr_err without disturbing sequencing.
        do_branch(32'h0000_1000, 32'h0000_0002);
        cyc(); check_val("ae_flag", {31'd0, u_if.addr_err}, 32'd1);
        cyc(); check_val("ae_seq", u_if.pc, 32'h0000_1006);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            u_if.stall             = ($urandom_range(0, 99) < 45);
            u_if.branch_taken      = ($urandom_range(0, 99) < 20);
            u_if.jump              = ($urandom_range(0, 99) < 10);
            u_if.exception         = ($urandom_range(0, 99) < 3);
            reset                  = ($urandom_range(0, 199) == 0);
            u_if.redirect_base     = $urandom;
            u_if.branch_offset_sl2 = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            u_if.jump_index        = 26'($urandom);
            u_if.exc_pc            = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
